// File: rtl/display_buf.sv
// rtl/display_buf.sv - character FIFO feeding an SPI mode-0 master that sends one byte per character
//
// Ports:
//   clk, rst_n       system clock (rising edge) and asynchronous active-low reset
//   DISP_write_en    one-cycle strobe that pushes DISP_write_data
//   DISP_write_data  7-bit ASCII character, stored as {1'b0, data}
//   DISP_clear       synchronous flush of the FIFO and the overflow flag
//   DISP_status      1 = FIFO not full, so a write will be accepted
//   buf_empty        1 = FIFO holds no entries
//   overflow         sticky; set when a write is dropped because the FIFO is full
//   tx_busy          1 = transmitter not idle
//   spi_sclk         serial clock, idles low
//   spi_mosi         serial data, MSB first
//   spi_cs_n         frame select, active-low
module display_buf #(
  parameter int DEPTH   = 16,
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       DISP_write_en,
  input  logic [6:0] DISP_write_data,
  input  logic       DISP_clear,
  output logic       DISP_status,
  output logic       buf_empty,
  output logic       overflow,
  output logic       tx_busy,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       spi_cs_n
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [1:0]    state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [3:0]    phase_q, phase_d;
  logic [DW-1:0] div_q, div_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          cs_n_q, cs_n_d;

  logic full;
  logic wr_acc;
  logic pop;

  // Fullness is judged on the registered count, so a same-cycle pop never
  // rescues a write into a full FIFO.
  always_comb begin
    full   = (count_q == FULL_CNT);
    wr_acc = DISP_write_en && !full && !DISP_clear;
    pop    = (state_q == ST_IDLE) && (count_q != '0);
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (DISP_clear) begin
      // A pop in the same cycle still hands its entry to the transmitter.
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)    rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_acc, pop})
        2'b10:   count_d = count_q + (AW + 1)'(1);
        2'b01:   count_d = count_q - (AW + 1)'(1);
        default: count_d = count_q;
      endcase
      if (DISP_write_en && full) overflow_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    phase_d = phase_q;
    div_d   = div_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          shift_d = mem_q[rd_ptr_q];
          phase_d = 4'd0;
          div_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          phase_d = phase_q + 4'd1;
          // Next bit is presented when the high (odd) phase ends.
          if (phase_q[0]) shift_d = {shift_q[6:0], 1'b0};
          if (phase_q == 4'd15) state_d = ST_GAP;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      ST_GAP: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = ST_IDLE;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // SPI pins are registered from next-state values so they line up with
    // the state they describe and never glitch.
    cs_n_d = (state_d != ST_SHIFT);
    sclk_d = (state_d == ST_SHIFT) && phase_d[0];
    mosi_d = (state_d == ST_SHIFT) && shift_d[7];
  end

  // Storage is not reset; a reset empties the FIFO through its pointers.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= {1'b0, DISP_write_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= ST_IDLE;
      shift_q    <= 8'h00;
      phase_q    <= 4'd0;
      div_q      <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      phase_q    <= phase_d;
      div_q      <= div_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
    end
  end

  assign DISP_status = !full;
  assign buf_empty   = (count_q == '0);
  assign overflow    = overflow_q;
  assign tx_busy     = (state_q != ST_IDLE);
  assign spi_sclk    = sclk_q;
  assign spi_mosi    = mosi_q;
  assign spi_cs_n    = cs_n_q;

endmodule

// File: tb/tb_display_buf.sv
// tb/tb_display_buf.sv - scoreboard bench for display_buf
module tb_display_buf;

  localparam int DEPTH   = 16;
  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       DISP_write_en = 1'b0;
  logic [6:0] DISP_write_data = 7'h00;
  logic       DISP_clear = 1'b0;
  logic       DISP_status, buf_empty, overflow, tx_busy;
  logic       spi_sclk, spi_mosi, spi_cs_n;

  display_buf #(.DEPTH(DEPTH), .CLK_DIV(CLK_DIV)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .DISP_write_en   (DISP_write_en),
    .DISP_write_data (DISP_write_data),
    .DISP_clear      (DISP_clear),
    .DISP_status     (DISP_status),
    .buf_empty       (buf_empty),
    .overflow        (overflow),
    .tx_busy         (tx_busy),
    .spi_sclk        (spi_sclk),
    .spi_mosi        (spi_mosi),
    .spi_cs_n        (spi_cs_n)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // SPI receiver, sampled on the falling clk edge away from DUT updates.
  int         frames = 0;
  int         low_cnt = 0;
  int         high_cnt = 1000;
  int         nbits = 0;
  logic       in_frame = 1'b0;
  logic       busy_bad = 1'b0;
  logic       sclk_prev = 1'b0;
  logic [7:0] rx = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 1'b0;
      high_cnt = 1000;
    end else if (!spi_cs_n) begin
      if (!in_frame) begin
        in_frame = 1'b1;
        low_cnt  = 0;
        nbits    = 0;
        rx       = 8'h00;
        busy_bad = 1'b0;
        check_eq("cs_gap_ge4", high_cnt >= CLK_DIV, 1);
      end
      low_cnt++;
      if (!tx_busy) busy_bad = 1'b1;
      if (spi_sclk && !sclk_prev) begin
        rx = {rx[6:0], spi_mosi};
        nbits++;
      end
    end else begin
      if (in_frame) begin
        in_frame = 1'b0;
        frames++;
        check_eq("cs_low_len", low_cnt, 16 * CLK_DIV);
        check_eq("bits_per_frame", nbits, 8);
        check_eq("busy_in_frame", busy_bad, 0);
        check_eq("frame_in_queue", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check_eq("frame_byte", rx, exp_q.pop_front());
        high_cnt = 0;
      end
      high_cnt++;
    end
    sclk_prev = spi_sclk;
  end

  // Drive one write; exp_tx says whether this character should reach the wire.
  task automatic wr(input logic [6:0] d, input logic exp_tx);
    DISP_write_en   = 1'b1;
    DISP_write_data = d;
    if (exp_tx) exp_q.push_back({1'b0, d});
    @(posedge clk);
    #1;
    DISP_write_en = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_busy) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq({tag, "_drain_in_time"}, n < budget, 1);
    check_eq({tag, "_queue_left"}, exp_q.size(), 0);
  endtask

  task automatic check_idle_flags(input string tag);
    check_eq({tag, "_status"},   DISP_status, 1);
    check_eq({tag, "_empty"},    buf_empty, 1);
    check_eq({tag, "_overflow"}, overflow, 0);
    check_eq({tag, "_busy"},     tx_busy, 0);
    check_eq({tag, "_sclk"},     spi_sclk, 0);
    check_eq({tag, "_mosi"},     spi_mosi, 0);
    check_eq({tag, "_cs_n"},     spi_cs_n, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  logic [6:0] hello [11] = '{7'h68, 7'h65, 7'h6C, 7'h6C, 7'h6F, 7'h20,
                             7'h77, 7'h6F, 7'h72, 7'h6C, 7'h64};
  int f0;

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check_idle_flags("reset");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single character 'h'
    f0 = frames;
    wr(7'h68, 1'b1);
    check_eq("t1_cs_before_pop", spi_cs_n, 1);
    check_eq("t1_empty_after_write", buf_empty, 0);
    @(posedge clk);
    #1;
    check_eq("t1_cs_after_pop", spi_cs_n, 0);
    check_eq("t1_mosi_bit7", spi_mosi, 0);
    check_eq("t1_empty_after_pop", buf_empty, 1);
    check_eq("t1_busy", tx_busy, 1);
    drain("t1", 200);
    check_eq("t1_frames", frames - f0, 1);

    // "hello world" back to back
    f0 = frames;
    for (int i = 0; i < 11; i++) wr(hello[i], 1'b1);
    check_eq("t2_overflow", overflow, 0);
    drain("t2", 1500);
    check_eq("t2_frames", frames - f0, 11);
    check_eq("t2_overflow_end", overflow, 0);

    // Overfill: writes on cycles 0..17, the last one is dropped
    f0 = frames;
    for (int i = 0; i < 18; i++) begin
      wr(7'(7'h41 + i), i != 17);
      if (i == 16) begin
        check_eq("t3_status_full", DISP_status, 0);
        check_eq("t3_overflow_pre", overflow, 0);
      end
    end
    check_eq("t3_status_after", DISP_status, 0);
    check_eq("t3_overflow", overflow, 1);
    drain("t3", 3000);
    check_eq("t3_frames", frames - f0, 17);
    check_eq("t3_overflow_sticky", overflow, 1);

    // Clear during phase 6 of the first of five queued frames
    f0 = frames;
    for (int i = 0; i < 5; i++) wr(7'(7'h30 + i), i == 0);
    repeat (21) @(posedge clk);
    #1;
    check_eq("t4_cs_mid_frame", spi_cs_n, 0);
    DISP_clear = 1'b1;
    @(posedge clk);
    #1;
    DISP_clear = 1'b0;
    check_eq("t4_empty", buf_empty, 1);
    check_eq("t4_overflow", overflow, 0);
    check_eq("t4_status", DISP_status, 1);
    drain("t4", 300);
    repeat (100) @(posedge clk);
    #1;
    check_eq("t4_frames", frames - f0, 1);

    // Clear and write in the same cycle on an empty FIFO
    f0 = frames;
    DISP_clear = 1'b1;
    wr(7'h65, 1'b0);
    DISP_clear = 1'b0;
    check_eq("t5_empty", buf_empty, 1);
    check_eq("t5_overflow", overflow, 0);
    repeat (100) @(posedge clk);
    #1;
    check_eq("t5_frames", frames - f0, 0);
    check_eq("t5_busy", tx_busy, 0);

    // Asynchronous reset during phase 5
    f0 = frames;
    wr(7'h5A, 1'b0);
    wr(7'h5B, 1'b0);
    repeat (21) @(posedge clk);
    #4;
    check_eq("t6_cs_before_reset", spi_cs_n, 0);
    check_eq("t6_sclk_phase5", spi_sclk, 1);
    rst_n = 1'b0;
    #1;
    check_idle_flags("t6_async");
    #17 rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (200) @(posedge clk);
    #1;
    check_eq("t6_frames", frames - f0, 0);
    check_idle_flags("t6_after");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
